// File: rtl/mux_scan_pkg.sv
// Shared constants for the scanning channel multiplexer: FSM encoding, mode values, parameter limits.
package mux_scan_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MANUAL = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    localparam int unsigned MAX_NCH   = 16;
    localparam int unsigned MAX_DWELL = 255;
    localparam int unsigned DWELL_W   = 8;

endpackage

// File: rtl/mux_scan_timer.sv
// Dwell counter and scan-channel stepper for auto-scan.
// scan_ch is the channel the scan lands on at this clock edge (next-state view),
// so the parent can register the matching data in the same edge.
module mux_scan_timer
    import mux_scan_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DWELL = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   clear,
    output logic                   adv,
    output logic [$clog2(NCH)-1:0] scan_ch,
    output logic                   wrap
);

    localparam int unsigned CHW = $clog2(NCH);
    localparam logic [DWELL_W-1:0] CNT_LAST = DWELL_W'(DWELL - 1);
    localparam logic [CHW-1:0]     CH_LAST  = CHW'(NCH - 1);

    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [CHW-1:0]     ch_q, ch_d;

    // Count dwell cycles; step the channel on the last one. Neither run nor clear freezes both.
    always_comb begin
        cnt_d = cnt_q;
        ch_d  = ch_q;
        adv   = 1'b0;
        if (clear) begin
            cnt_d = '0;
            ch_d  = '0;
        end else if (run) begin
            if (cnt_q == CNT_LAST) begin
                adv   = 1'b1;
                cnt_d = '0;
                ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + CHW'(1);
            end else begin
                cnt_d = cnt_q + DWELL_W'(1);
            end
        end
    end

    assign scan_ch = ch_d;
    // Level: currently on the last channel, so an advance now wraps to 0.
    assign wrap    = (ch_q == CH_LAST);

    // Timer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ch_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            ch_q  <= ch_d;
        end
    end

endmodule

// File: rtl/mux_scan_nch.sv
// N-channel multiplexer with manual select and timed auto-scan; all outputs registered.
// Outputs are computed from the state being entered, so data lags sel/in_bus by one clock.
module mux_scan_nch
    import mux_scan_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned NCH   = 4,
    parameter int unsigned DWELL = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*WIDTH-1:0]   in_bus,
    input  logic                   enable,
    input  logic                   mode,
    input  logic [$clog2(NCH)-1:0] sel,
    output logic [WIDTH-1:0]       out,
    output logic [$clog2(NCH)-1:0] out_ch,
    output logic                   out_valid,
    output logic                   wrap,
    output logic                   sel_err
);

    localparam int unsigned SELW = $clog2(NCH);
    localparam logic [SELW:0] NCH_L = (SELW + 1)'(NCH);

    if (NCH < 2 || NCH > MAX_NCH) begin : g_bad_nch
        $error("mux_scan_nch: NCH out of range");
    end
    if (DWELL < 1 || DWELL > MAX_DWELL) begin : g_bad_dwell
        $error("mux_scan_nch: DWELL out of range");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             sel_err_q, sel_err_d;

    logic             sel_ok;
    logic             tmr_run, tmr_clear, tmr_adv, tmr_last;
    logic [SELW-1:0]  scan_ch;

    assign sel_ok = ({1'b0, sel} < NCH_L);

    // Next state: enable dominates, otherwise mode picks manual or scan.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (mode == MODE_AUTO) begin
            state_d = ST_SCAN;
        end else begin
            state_d = ST_MANUAL;
        end
    end

    // Entering scan restarts the timer; staying in scan lets it count; anything else freezes it.
    assign tmr_clear = (state_d == ST_SCAN) && (state_q != ST_SCAN);
    assign tmr_run   = (state_d == ST_SCAN) && (state_q == ST_SCAN);

    mux_scan_timer #(
        .NCH   (NCH),
        .DWELL (DWELL)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (tmr_run),
        .clear   (tmr_clear),
        .adv     (tmr_adv),
        .scan_ch (scan_ch),
        .wrap    (tmr_last)
    );

    // Output next-values for the state being entered; idle holds data and channel.
    always_comb begin
        out_d     = out_q;
        out_ch_d  = out_ch_q;
        valid_d   = 1'b0;
        wrap_d    = 1'b0;
        sel_err_d = 1'b0;
        case (state_d)
            ST_MANUAL: begin
                if (sel_ok) begin
                    out_d    = in_bus[int'(sel)*WIDTH +: WIDTH];
                    out_ch_d = sel;
                    valid_d  = 1'b1;
                end else begin
                    out_d     = '0;
                    sel_err_d = 1'b1;
                end
            end
            ST_SCAN: begin
                out_d    = in_bus[int'(scan_ch)*WIDTH +: WIDTH];
                out_ch_d = scan_ch;
                valid_d  = 1'b1;
                wrap_d   = tmr_adv & tmr_last;
            end
            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            out_q     <= '0;
            out_ch_q  <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            out_ch_q  <= out_ch_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = valid_q;
    assign wrap      = wrap_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_scan_nch.sv
// Directed bench for mux_scan_nch: three configurations sharing clock and control.
module tb_mux_scan_nch;

    logic clk = 1'b0;
    logic rst_n, enable, mode;

    always #5 clk = ~clk;

    // NCH=4, WIDTH=8, DWELL=3
    logic [31:0] in4 = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    logic [1:0]  sel4;
    logic [7:0]  out4;
    logic [1:0]  ch4;
    logic        vld4, wrap4, err4;

    // NCH=5, WIDTH=8, DWELL=2
    logic [39:0] in5 = {8'h54, 8'h43, 8'h32, 8'h21, 8'h10};
    logic [2:0]  sel5;
    logic [7:0]  out5;
    logic [2:0]  ch5;
    logic        vld5, wrap5, err5;

    // NCH=2, WIDTH=8, DWELL=1
    logic [15:0] in2 = {8'h5A, 8'hA5};
    logic        sel2;
    logic [7:0]  out2;
    logic        ch2;
    logic        vld2, wrap2, err2;

    int checks = 0;
    int errors = 0;

    mux_scan_nch #(.WIDTH(8), .NCH(4), .DWELL(3)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_bus(in4), .enable(enable), .mode(mode), .sel(sel4),
        .out(out4), .out_ch(ch4), .out_valid(vld4), .wrap(wrap4), .sel_err(err4)
    );

    mux_scan_nch #(.WIDTH(8), .NCH(5), .DWELL(2)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_bus(in5), .enable(enable), .mode(mode), .sel(sel5),
        .out(out5), .out_ch(ch5), .out_valid(vld5), .wrap(wrap5), .sel_err(err5)
    );

    mux_scan_nch #(.WIDTH(8), .NCH(2), .DWELL(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_bus(in2), .enable(enable), .mode(mode), .sel(sel2),
        .out(out2), .out_ch(ch2), .out_valid(vld2), .wrap(wrap2), .sel_err(err2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] b4(input int k);
        return 8'(160 + 17 * k);
    endfunction

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        mode   = 1'b0;
        sel4   = 2'd0;
        sel5   = 3'd0;
        sel2   = 1'b0;

        // reset state
        #12;
        chk("rst_out",   32'(out4),  32'h0);
        chk("rst_ch",    32'(ch4),   32'h0);
        chk("rst_valid", 32'(vld4),  32'h0);
        chk("rst_wrap",  32'(wrap4), 32'h0);
        chk("rst_err",   32'(err4),  32'h0);
        rst_n  = 1'b1;

        // manual select 0..3
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel4 = 2'(k);
            if (k == 1) begin
                #3;
                chk("man_latency", 32'(out4), 32'(b4(0)));
            end
            tick();
            chk("man_out",   32'(out4), 32'(b4(k)));
            chk("man_ch",    32'(ch4),  32'(k));
            chk("man_valid", 32'(vld4), 32'h1);
        end

        // asynchronous reset mid-cycle while valid
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out",   32'(out4), 32'h0);
        chk("arst_ch",    32'(ch4),  32'h0);
        chk("arst_valid", 32'(vld4), 32'h0);
        #1 rst_n = 1'b1;
        tick();
        chk("resume_out", 32'(out4), 32'(b4(3)));
        chk("resume_ch",  32'(ch4),  32'h3);

        // auto-scan, DWELL=3
        mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("scan_ch",    32'(ch4),   32'((i / 3) % 4));
            chk("scan_out",   32'(out4),  32'(b4((i / 3) % 4)));
            chk("scan_wrap",  32'(wrap4), 32'(i == 12));
            chk("scan_valid", 32'(vld4),  32'h1);
        end

        // enable drop on channel 2, mid-dwell
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_valid", 32'(vld4),  32'h0);
            chk("idle_ch",    32'(ch4),   32'h2);
            chk("idle_out",   32'(out4),  32'(b4(2)));
            chk("idle_wrap",  32'(wrap4), 32'h0);
        end
        enable = 1'b1;
        for (int j = 0; j < 7; j++) begin
            tick();
            chk("rescan_ch",    32'(ch4),  32'(j / 3));
            chk("rescan_valid", 32'(vld4), 32'h1);
        end

        // scan -> manual with sel=1
        mode = 1'b0;
        sel4 = 2'd1;
        tick();
        chk("sw_ch",    32'(ch4),   32'h1);
        chk("sw_out",   32'(out4),  32'(b4(1)));
        chk("sw_wrap",  32'(wrap4), 32'h0);
        chk("sw_valid", 32'(vld4),  32'h1);

        // NCH=5: last legal channel, then illegal selects, then recovery
        sel5 = 3'd4;
        tick();
        chk("n5_out", 32'(out5), 32'h54);
        chk("n5_ch",  32'(ch5),  32'h4);
        chk("n5_err", 32'(err5), 32'h0);
        sel5 = 3'd5;
        tick();
        chk("n5_sel5_err",   32'(err5), 32'h1);
        chk("n5_sel5_valid", 32'(vld5), 32'h0);
        sel5 = 3'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ill_out",   32'(out5), 32'h0);
            chk("ill_valid", 32'(vld5), 32'h0);
            chk("ill_err",   32'(err5), 32'h1);
            chk("ill_ch",    32'(ch5),  32'h4);
        end
        sel5 = 3'd2;
        tick();
        chk("rec_out",   32'(out5), 32'h32);
        chk("rec_ch",    32'(ch5),  32'h2);
        chk("rec_valid", 32'(vld5), 32'h1);
        chk("rec_err",   32'(err5), 32'h0);

        // enable low with a simultaneous mode change: idle wins
        enable = 1'b0;
        mode   = 1'b1;
        tick();
        chk("prio_valid4", 32'(vld4), 32'h0);
        chk("prio_ch4",    32'(ch4),  32'h1);
        chk("prio_valid2", 32'(vld2), 32'h0);

        // NCH=2, DWELL=1: channel steps every clock, wrap every 2
        enable = 1'b1;
        tick();
        chk("d1_entry_ch",   32'(ch2),   32'h0);
        chk("d1_entry_out",  32'(out2),  32'hA5);
        chk("d1_entry_wrap", 32'(wrap2), 32'h0);
        for (int i = 1; i < 7; i++) begin
            tick();
            chk("d1_ch",   32'(ch2),   32'(i % 2));
            chk("d1_out",  32'(out2),  (i % 2 == 1) ? 32'h5A : 32'hA5);
            chk("d1_wrap", 32'(wrap2), 32'(i % 2 == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
